// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush and memory-hold handling.
// Optional hazard statistics counters are enabled by defining HAZARD_STATS_EN.
module id_ex_stage #(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [31:0]   id_instr,
    input  logic          id_valid,
    input  logic          id_RegDst,
    input  logic          id_ALUSrc,
    input  logic          id_MemtoReg,
    input  logic          id_RegWrite,
    input  logic          id_MemRead,
    input  logic          id_MemWrite,
    input  logic          id_Branch,
    input  logic          id_Jump,
    input  logic [1:0]    id_ALUOp,
    input  logic [DW-1:0] id_rd1,
    input  logic [DW-1:0] id_rd2,
    input  logic [DW-1:0] id_imm,
    input  logic [DW-1:0] id_pc4,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic          flush,
    input  logic          mem_hold,
    output logic          stall_o,
    output logic          ex_valid,
    output logic          ex_RegDst,
    output logic          ex_ALUSrc,
    output logic          ex_MemtoReg,
    output logic          ex_RegWrite,
    output logic          ex_MemRead,
    output logic          ex_MemWrite,
    output logic          ex_Branch,
    output logic          ex_Jump,
    output logic [1:0]    ex_ALUOp,
    output logic [DW-1:0] ex_rd1,
    output logic [DW-1:0] ex_rd2,
    output logic [DW-1:0] ex_imm,
    output logic [DW-1:0] ex_pc4,
    output logic [RW-1:0] ex_rs,
    output logic [RW-1:0] ex_rt,
`ifdef HAZARD_STATS_EN
    output logic [31:0]   bubble_cnt,
    output logic [31:0]   flush_cnt,
`endif
    output logic [RW-1:0] ex_rd
);

    typedef struct packed {
        logic       RegDst;
        logic       ALUSrc;
        logic       MemtoReg;
        logic       RegWrite;
        logic       MemRead;
        logic       MemWrite;
        logic       Branch;
        logic       Jump;
        logic [1:0] ALUOp;
    } ctrl_t;

    logic          valid_q, valid_d;
    ctrl_t         ctrl_q, ctrl_d;
    ctrl_t         id_ctrl;
    logic [DW-1:0] rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d, pc4_q, pc4_d;
    logic [RW-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;

    logic id_bubble;
    logic uses_rt;
    logic lu;

    // Only a definite 1 on a decoder line counts; X or Z collapses to 0 before entering EX.
    function automatic logic clean(input logic b);
        return (b === 1'b1);
    endfunction

    always_comb begin
        id_ctrl.RegDst   = clean(id_RegDst);
        id_ctrl.ALUSrc   = clean(id_ALUSrc);
        id_ctrl.MemtoReg = clean(id_MemtoReg);
        id_ctrl.RegWrite = clean(id_RegWrite);
        id_ctrl.MemRead  = clean(id_MemRead);
        id_ctrl.MemWrite = clean(id_MemWrite);
        id_ctrl.Branch   = clean(id_Branch);
        id_ctrl.Jump     = clean(id_Jump);
        id_ctrl.ALUOp    = id_ALUOp;
    end

    assign id_bubble = ~id_valid | (id_instr == '0);
    assign uses_rt   = ~id_ALUSrc | id_MemWrite;
    assign lu        = valid_q & ctrl_q.MemRead & (rt_q != '0) & ~id_bubble &
                       ((rt_q == id_rs) | (uses_rt & (rt_q == id_rt)));
    assign stall_o   = lu | mem_hold;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        imm_d   = imm_q;
        pc4_d   = pc4_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        if (flush || (!mem_hold && (lu || id_bubble))) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            rd1_d   = '0;
            rd2_d   = '0;
            imm_d   = '0;
            pc4_d   = '0;
            rs_d    = '0;
            rt_d    = '0;
            rd_d    = '0;
        end else if (!mem_hold) begin
            valid_d = 1'b1;
            ctrl_d  = id_ctrl;
            rd1_d   = id_rd1;
            rd2_d   = id_rd2;
            imm_d   = id_imm;
            pc4_d   = id_pc4;
            rs_d    = id_rs;
            rt_d    = id_rt;
            rd_d    = id_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            pc4_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            pc4_q   <= pc4_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_RegDst   = ctrl_q.RegDst;
    assign ex_ALUSrc   = ctrl_q.ALUSrc;
    assign ex_MemtoReg = ctrl_q.MemtoReg;
    assign ex_RegWrite = ctrl_q.RegWrite;
    assign ex_MemRead  = ctrl_q.MemRead;
    assign ex_MemWrite = ctrl_q.MemWrite;
    assign ex_Branch   = ctrl_q.Branch;
    assign ex_Jump     = ctrl_q.Jump;
    assign ex_ALUOp    = ctrl_q.ALUOp;
    assign ex_rd1      = rd1_q;
    assign ex_rd2      = rd2_q;
    assign ex_imm      = imm_q;
    assign ex_pc4      = pc4_q;
    assign ex_rs       = rs_q;
    assign ex_rt       = rt_q;
    assign ex_rd       = rd_q;

`ifdef HAZARD_STATS_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Only bubbles actually caused by lu are counted; flush or hold on the same edge masks them.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (lu && !mem_hold && !flush && (bubble_cnt_q != '1))
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        if (flush && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic against a reference model.
// Counter checks are compiled in when HAZARD_STATS_EN is defined.
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic [7:0]  ctrl;   // {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,Jump}
        logic [1:0]  ALUOp;
        logic [31:0] rd1, rd2, imm, pc4;
        logic [4:0]  rs, rt, rd;
    } ex_t;

    localparam logic [7:0] C_LW   = 8'b0111_1000;
    localparam logic [7:0] C_ADD  = 8'b1001_0000;
    localparam logic [7:0] C_SW   = 8'b0100_0100;
    localparam logic [7:0] C_BEQ  = 8'b0000_0010;
    localparam logic [7:0] C_ADDI = 8'b0101_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [31:0] id_instr = '0;
    logic id_valid = 1'b0;
    logic id_RegDst = 0, id_ALUSrc = 0, id_MemtoReg = 0, id_RegWrite = 0;
    logic id_MemRead = 0, id_MemWrite = 0, id_Branch = 0, id_Jump = 0;
    logic [1:0] id_ALUOp = '0;
    logic [31:0] id_rd1 = '0, id_rd2 = '0, id_imm = '0, id_pc4 = '0;
    logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic flush = 1'b0, mem_hold = 1'b0;

    logic stall_o, ex_valid;
    logic ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch, ex_Jump;
    logic [1:0] ex_ALUOp;
    logic [31:0] ex_rd1, ex_rd2, ex_imm, ex_pc4;
    logic [4:0] ex_rs, ex_rt, ex_rd;
`ifdef HAZARD_STATS_EN
    logic [31:0] bubble_cnt, flush_cnt;
`endif

    int checks = 0;
    int errors = 0;
    ex_t m;                 // model of the EX slot
    longint bcnt, fcnt;     // model of the statistics counters

    id_ex_stage #(.DW(32), .RW(5)) dut (
        .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid),
        .id_RegDst(id_RegDst), .id_ALUSrc(id_ALUSrc), .id_MemtoReg(id_MemtoReg),
        .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
        .id_Branch(id_Branch), .id_Jump(id_Jump), .id_ALUOp(id_ALUOp),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_pc4(id_pc4),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush), .mem_hold(mem_hold),
        .stall_o(stall_o), .ex_valid(ex_valid), .ex_RegDst(ex_RegDst), .ex_ALUSrc(ex_ALUSrc),
        .ex_MemtoReg(ex_MemtoReg), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
        .ex_MemWrite(ex_MemWrite), .ex_Branch(ex_Branch), .ex_Jump(ex_Jump),
        .ex_ALUOp(ex_ALUOp), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
        .ex_pc4(ex_pc4), .ex_rs(ex_rs), .ex_rt(ex_rt),
`ifdef HAZARD_STATS_EN
        .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt),
`endif
        .ex_rd(ex_rd)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    function automatic ex_t get_dut();
        return {ex_valid, ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead,
                ex_MemWrite, ex_Branch, ex_Jump, ex_ALUOp, ex_rd1, ex_rd2, ex_imm,
                ex_pc4, ex_rs, ex_rt, ex_rd};
    endfunction

    // A stall is needed when the load sitting in EX writes a non-zero register the ID instruction reads.
    function automatic logic model_lu(input ex_t cur);
        logic id_real, is_load, reads_rt;
        id_real  = id_valid && (id_instr != 0);
        is_load  = cur.valid && cur.ctrl[3] && (cur.rt != 0);
        reads_rt = !id_ALUSrc || id_MemWrite;
        return id_real && is_load && ((cur.rt == id_rs) || (reads_rt && cur.rt == id_rt));
    endfunction

    function automatic ex_t model_next(input ex_t cur);
        ex_t n;
        n = '0;
        if (flush) n = '0;
        else if (mem_hold) n = cur;
        else if (model_lu(cur) || !id_valid || id_instr == 0) n = '0;
        else begin
            n.valid = 1'b1;
            n.ctrl  = {id_RegDst === 1'b1, id_ALUSrc === 1'b1, id_MemtoReg === 1'b1,
                       id_RegWrite === 1'b1, id_MemRead === 1'b1, id_MemWrite === 1'b1,
                       id_Branch === 1'b1, id_Jump === 1'b1};
            n.ALUOp = id_ALUOp;
            n.rd1 = id_rd1; n.rd2 = id_rd2; n.imm = id_imm; n.pc4 = id_pc4;
            n.rs = id_rs; n.rt = id_rt; n.rd = id_rd;
        end
        return n;
    endfunction

    task automatic tick();
        ex_t nx;
        nx = model_next(m);
        if (model_lu(m) && !mem_hold && !flush && bcnt < 64'hFFFF_FFFF) bcnt++;
        if (flush && fcnt < 64'hFFFF_FFFF) fcnt++;
        @(posedge clk);
        m = nx;
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic v, input logic [7:0] c,
                         input logic [1:0] aluop, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd);
        id_instr = instr; id_valid = v;
        {id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite,
         id_Branch, id_Jump} = c;
        id_ALUOp = aluop; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom; id_pc4 = $urandom;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; flush = 0; mem_hold = 0;
        drive(32'h0, 1'b0, 8'h00, 2'b00, 5'd0, 5'd0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        m = '0; bcnt = 0; fcnt = 0;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (get_dut() !== ex_t'(0)) begin
            errors++; $display("FAIL reset_state: got %h expected %h", get_dut(), ex_t'(0));
        end
        checks++;
        if (stall_o !== 1'b0) begin
            errors++; $display("FAIL reset_stall: got %b expected 0", stall_o);
        end
    endtask

    task automatic test_load_use();
        drive(32'h8d28_0000, 1'b1, C_LW, 2'b00, 5'd9, 5'd8, 5'd0);
        tick();
        drive(32'h010b_5020, 1'b1, C_ADD, 2'b10, 5'd8, 5'd11, 5'd10);
        #1;
        checks++;
        if (stall_o !== 1'b1) begin
            errors++; $display("FAIL lu_stall_assert: got %b expected 1", stall_o);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b0 || ex_RegWrite !== 1'b0 || get_dut() !== m) begin
            errors++; $display("FAIL lu_bubble: got %h expected %h", get_dut(), m);
        end
        checks++;
        if (stall_o !== 1'b0) begin
            errors++; $display("FAIL lu_stall_release: got %b expected 0", stall_o);
        end
        tick();
        checks++;
        if (ex_rs !== 5'd8 || ex_RegDst !== 1'b1 || ex_ALUOp !== 2'b10 || get_dut() !== m) begin
            errors++; $display("FAIL lu_replay: got %h expected %h", get_dut(), m);
        end
    endtask

    task automatic test_sw_and_zero();
        drive(32'h8d28_0000, 1'b1, C_LW, 2'b00, 5'd9, 5'd8, 5'd0);
        tick();
        drive(32'had28_0004, 1'b1, C_SW, 2'b00, 5'd9, 5'd8, 5'd0);
        #1;
        checks++;
        if (stall_o !== 1'b1) begin
            errors++; $display("FAIL sw_store_data_stall: got %b expected 1", stall_o);
        end
        drive(32'h2128_0004, 1'b1, C_ADDI, 2'b00, 5'd9, 5'd8, 5'd0);
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++; $display("FAIL addi_rt_no_stall: got %b expected 0", stall_o);
        end
        tick();
        drive(32'h8d20_0000, 1'b1, C_LW, 2'b00, 5'd9, 5'd0, 5'd0);
        tick();
        drive(32'h0000_5020, 1'b1, C_ADD, 2'b10, 5'd0, 5'd0, 5'd10);
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++; $display("FAIL zero_dest_no_stall: got %b expected 0", stall_o);
        end
        tick();
        checks++;
        if (get_dut() !== m) begin
            errors++; $display("FAIL zero_dest_load: got %h expected %h", get_dut(), m);
        end
    endtask

    task automatic test_nop();
        drive(32'h0, 1'b1, 8'h00, 2'b00, 5'd1, 5'd2, 5'd3);
        id_RegWrite = 1'bx; id_MemRead = 1'bx; id_MemWrite = 1'bx;
        tick();
        checks++;
        if (ex_valid !== 1'b0 || ex_RegWrite !== 1'b0 || ex_MemWrite !== 1'b0 ||
            $isunknown(get_dut()) || get_dut() !== ex_t'(0)) begin
            errors++; $display("FAIL nop_sanitise: got %h expected %h", get_dut(), ex_t'(0));
        end
        drive(32'h012a_4020, 1'b1, C_ADD, 2'b10, 5'd9, 5'd10, 5'd8);
        id_RegDst = 1'bx; id_MemtoReg = 1'bx;
        tick();
        checks++;
        if ($isunknown(get_dut()) || ex_MemtoReg !== 1'b0 || get_dut() !== m) begin
            errors++; $display("FAIL x_ctrl_sanitise: got %h expected %h", get_dut(), m);
        end
    endtask

    task automatic test_flush_hold();
        ex_t snap;
        drive(32'h1109_0003, 1'b1, C_BEQ, 2'b01, 5'd8, 5'd9, 5'd0);
        flush = 1'b1; mem_hold = 1'b1;
        tick();
        flush = 1'b0; mem_hold = 1'b0;
        checks++;
        if (ex_valid !== 1'b0 || ex_Branch !== 1'b0 || get_dut() !== m) begin
            errors++; $display("FAIL flush_beats_hold: got %h expected %h", get_dut(), m);
        end
        drive(32'h8d28_0000, 1'b1, C_LW, 2'b00, 5'd9, 5'd8, 5'd0);
        tick();
        snap = m;
        mem_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive($urandom | 32'h1, 1'b1, 8'($urandom), 2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
            #1;
            checks++;
            if (stall_o !== 1'b1) begin
                errors++; $display("FAIL hold_stall[%0d]: got %b expected 1", i, stall_o);
            end
            tick();
            checks++;
            if (get_dut() !== snap) begin
                errors++; $display("FAIL hold_freeze[%0d]: got %h expected %h", i, get_dut(), snap);
            end
        end
        mem_hold = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        drive(32'h8d28_0000, 1'b1, C_LW, 2'b00, 5'd9, 5'd8, 5'd0);
        tick();
        drive(32'h010b_5020, 1'b1, C_ADD, 2'b10, 5'd8, 5'd11, 5'd10);
        #1;
        checks++;
        if (stall_o !== 1'b1 || ex_MemRead !== 1'b1) begin
            errors++; $display("FAIL pre_reset_stall: got %b expected 1", stall_o);
        end
        mem_hold = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        m = '0; bcnt = 0; fcnt = 0;
        checks++;
        if (get_dut() !== ex_t'(0) || stall_o !== 1'b1) begin
            errors++; $display("FAIL async_reset_hold: got %h/%b expected %h/1", get_dut(), stall_o, ex_t'(0));
        end
        mem_hold = 1'b0;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++; $display("FAIL async_reset_stall: got %b expected 0", stall_o);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ins;
            ins = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom | 32'h1);
            drive(ins, $urandom_range(0, 7) != 0,
                  {1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom), 1'($urandom)},
                  2'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)));
            flush    = ($urandom_range(0, 15) == 0);
            mem_hold = ($urandom_range(0, 4) == 0);
            #1;
            checks++;
            if (stall_o !== (model_lu(m) | mem_hold)) begin
                errors++; $display("FAIL rand_stall[%0d]: got %b expected %b", i, stall_o, model_lu(m) | mem_hold);
            end
            tick();
            checks++;
            if (get_dut() !== m) begin
                errors++; $display("FAIL rand_state[%0d]: got %h expected %h", i, get_dut(), m);
            end
        end
        flush = 1'b0; mem_hold = 1'b0;
    endtask

`ifdef HAZARD_STATS_EN
    task automatic test_stats();
        apply_reset();
        for (int p = 0; p < 2; p++) begin
            drive(32'h8d28_0000, 1'b1, C_LW, 2'b00, 5'd9, 5'(5 + p), 5'd0);
            tick();
            drive(32'h010b_5020, 1'b1, C_ADD, 2'b10, 5'(5 + p), 5'd11, 5'd10);
            tick();
            tick();
        end
        flush = 1'b1; tick(); flush = 1'b0;
        drive(32'h8d28_0000, 1'b1, C_LW, 2'b00, 5'd9, 5'd7, 5'd0);
        tick();
        drive(32'h010b_5020, 1'b1, C_ADD, 2'b10, 5'd7, 5'd11, 5'd10);
        mem_hold = 1'b1; tick(); mem_hold = 1'b0;
        checks++;
        if (bubble_cnt !== 32'd2 || bubble_cnt !== 32'(bcnt)) begin
            errors++; $display("FAIL bubble_cnt: got %0d expected %0d", bubble_cnt, bcnt);
        end
        checks++;
        if (flush_cnt !== 32'd1 || flush_cnt !== 32'(fcnt)) begin
            errors++; $display("FAIL flush_cnt: got %0d expected %0d", flush_cnt, fcnt);
        end
        force dut.bubble_cnt_q = 32'hFFFF_FFFF;
        #1 release dut.bubble_cnt_q;
        bcnt = 64'hFFFF_FFFF;
        tick();
        checks++;
        if (bubble_cnt !== 32'hFFFF_FFFF || bubble_cnt !== 32'(bcnt)) begin
            errors++; $display("FAIL bubble_cnt_sat: got %h expected ffffffff", bubble_cnt);
        end
    endtask
`endif

    initial begin
        m = '0; bcnt = 0; fcnt = 0;
        test_reset();
        test_load_use();
        test_sw_and_zero();
        test_nop();
        test_flush_hold();
        test_reset_mid_stall();
        test_random();
`ifdef HAZARD_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
